// File: rtl/tenkey_pkg.sv
// Shared definitions for the ten-key keypad front end.
// Holds the FSM state encoding, the key count and the pattern helper functions.
package tenkey_pkg;

  localparam int NKEYS = 10;
  // Widest debounced pattern: ten digit keys plus the optional close key.
  localparam int MAXW  = NKEYS + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Binary index of the set bit in a one-hot digit pattern (0 when no bit is set).
  function automatic logic [3:0] onehot2dig(input logic [NKEYS-1:0] oh);
    logic [3:0] dig;
    dig = 4'd0;
    for (int i = 0; i < NKEYS; i++) begin
      dig = oh[i] ? 4'(i) : dig;
    end
    return dig;
  endfunction

  // True when exactly one bit of the pattern is set.
  function automatic logic is_onehot(input logic [MAXW-1:0] v);
    return (v != {MAXW{1'b0}}) && ((v & (v - {{(MAXW-1){1'b0}}, 1'b1})) == {MAXW{1'b0}});
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a shared stability counter for a W-bit key pattern.
// The counter restarts on any change of the synchronised pattern and saturates at
// DEB_CYCLES; stable is high once the pattern has held for DEB_CYCLES cycles.
module key_debounce #(
  parameter int W          = 10,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic         ck,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         stable
);

  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB_CYCLES);

  logic [W-1:0]     meta_r;
  logic [W-1:0]     samp_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous key levels into the ck domain.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      meta_r <= {W{1'b0}};
      samp_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      samp_r <= meta_r;
    end
  end

  // Count cycles the sampled pattern has held; clearing on the same edge the pattern
  // changes keeps stable from ever describing a stale pattern.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (meta_r != samp_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != DEB_C) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q      = samp_r;
  assign stable = (cnt_r == DEB_C);

endmodule

// File: rtl/tenkey_encoder.sv
// Keypad front end for the electronic lock: debounces keys 0-9 and emits one
// registered one-hot strobe per accepted single-key press, plus the digit code.
// Optional feature macro: TENKEY_CLOSE_EN adds a debounced close key with its own strobe.
module tenkey_encoder
  import tenkey_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             ck,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_raw,
`ifdef TENKEY_CLOSE_EN
  input  logic             close_raw,
  output logic             close,
`endif
  output logic [NKEYS-1:0] tenkey,
  output logic [3:0]       digit,
  output logic             valid,
  output logic             busy
);

`ifdef TENKEY_CLOSE_EN
  localparam int DW = NKEYS + 1;
`else
  localparam int DW = NKEYS;
`endif

  logic [DW-1:0]    raw_s;
  logic [DW-1:0]    samp_s;
  logic             stable_s;
  logic [NKEYS-1:0] key_s;
  logic             close_bit_s;
  logic             zero_s;
  logic             onehot_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic             accept_key_s;
  logic             accept_close_s;

  logic [NKEYS-1:0] tenkey_r;
  logic [3:0]       digit_r;
  logic             valid_r;
  logic             busy_r;

`ifdef TENKEY_CLOSE_EN
  logic             close_r;
  assign raw_s       = {close_raw, key_raw};
  assign close_bit_s = samp_s[NKEYS];
`else
  assign raw_s       = key_raw;
  assign close_bit_s = 1'b0;
`endif

  key_debounce #(
    .W          (DW),
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb (
    .ck     (ck),
    .reset  (reset),
    .d      (raw_s),
    .q      (samp_s),
    .stable (stable_s)
  );

  assign key_s    = samp_s[NKEYS-1:0];
  assign zero_s   = (samp_s == {DW{1'b0}});
  assign onehot_s = is_onehot(MAXW'(samp_s));

  // Next-state logic; accept_s marks the single SETTLE->PRESSED transition.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!zero_s) state_nxt_s = SETTLE;
        else         state_nxt_s = IDLE;
      end
      SETTLE: begin
        if (stable_s) begin
          if (zero_s) begin
            state_nxt_s = IDLE;
          end else if (onehot_s) begin
            state_nxt_s = PRESSED;
            accept_s    = 1'b1;
          end else begin
            state_nxt_s = RELEASE;
          end
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      // Stability only drops here when the held pattern changes (extra key or release).
      PRESSED: begin
        if (!stable_s) state_nxt_s = RELEASE;
        else           state_nxt_s = PRESSED;
      end
      RELEASE: begin
        if (stable_s && zero_s) state_nxt_s = IDLE;
        else                    state_nxt_s = RELEASE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    accept_key_s   = accept_s & ~close_bit_s;
    accept_close_s = accept_s & close_bit_s;
  end

  // FSM state register.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Registered strobes, held digit code and busy flag.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      tenkey_r <= {NKEYS{1'b0}};
      digit_r  <= 4'd0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      tenkey_r <= accept_key_s ? key_s : {NKEYS{1'b0}};
      digit_r  <= accept_key_s ? onehot2dig(key_s) : digit_r;
      valid_r  <= accept_key_s;
      busy_r   <= (state_nxt_s != IDLE);
    end
  end

`ifdef TENKEY_CLOSE_EN
  // Close strobe, one cycle per accepted close press.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) close_r <= 1'b0;
    else        close_r <= accept_close_s;
  end
  assign close = close_r;
`endif

  assign tenkey = tenkey_r;
  assign digit  = digit_r;
  assign valid  = valid_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_tenkey_encoder.sv
// Self-checking bench for tenkey_encoder (DEB_CYCLES=4): table of press vectors plus
// hand-written reset, bounce, multi-key and close sequences.
module tb_tenkey_encoder;

  logic       ck;
  logic       reset;
  logic [9:0] key_raw;
  logic [9:0] tenkey;
  logic [3:0] digit;
  logic       valid;
  logic       busy;
`ifdef TENKEY_CLOSE_EN
  logic       close_raw;
  logic       close;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  tenkey_encoder #(.DEB_CYCLES(4), .CNT_W(8)) dut (
    .ck      (ck),
    .reset   (reset),
    .key_raw (key_raw),
`ifdef TENKEY_CLOSE_EN
    .close_raw (close_raw),
    .close     (close),
`endif
    .tenkey  (tenkey),
    .digit   (digit),
    .valid   (valid),
    .busy    (busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [9:0] pat;
    int         hold;
    int         exp_cnt;
    logic [9:0] exp_tk;
    logic [3:0] exp_dg;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Run n cycles sampling 1 time unit after each rising edge; report strobe count,
  // cycle of the first strobe, its values, first cycle with busy low, and valid errors.
  task automatic watch(input int n, output int cnt, output int first,
                       output logic [9:0] tk, output logic [3:0] dg,
                       output int busy_low, output int vbad);
    cnt = 0; first = -1; tk = 10'h000; dg = 4'd0; busy_low = -1; vbad = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge ck); #1;
      if (tenkey != 10'h000) begin
        cnt++;
        if (first < 0) begin
          first = k; tk = tenkey; dg = digit;
        end
      end
      if (valid != (tenkey != 10'h000)) vbad++;
      if (!busy && busy_low < 0) busy_low = k;
    end
  endtask

  initial begin
    int cnt, first, blow, vbad;
    logic [9:0] tk;
    logic [3:0] dg;

    vecs[0]  = '{10'h080, 20, 1, 10'h080, 4'd7};
    vecs[1]  = '{10'h001, 12, 1, 10'h001, 4'd0};
    vecs[2]  = '{10'h008,  3, 0, 10'h000, 4'd0};
    vecs[3]  = '{10'h202, 12, 0, 10'h000, 4'd0};
    vecs[4]  = '{10'h020, 12, 1, 10'h020, 4'd5};
    vecs[5]  = '{10'h002, 12, 1, 10'h002, 4'd1};
    vecs[6]  = '{10'h080, 12, 1, 10'h080, 4'd7};
    vecs[7]  = '{10'h200, 12, 1, 10'h200, 4'd9};
    vecs[8]  = '{10'h200, 12, 1, 10'h200, 4'd9};
    vecs[9]  = '{10'h200, 12, 1, 10'h200, 4'd9};
    vecs[10] = '{10'h200, 12, 1, 10'h200, 4'd9};

    // Reset held with key1 down: all outputs low.
    reset = 1'b0; key_raw = 10'h002;
`ifdef TENKEY_CLOSE_EN
    close_raw = 1'b0;
`endif
    repeat (5) @(posedge ck);
    #1;
    check("rst_tenkey", int'(tenkey), 0);
    check("rst_digit",  int'(digit),  0);
    check("rst_valid",  int'(valid),  0);
    check("rst_busy",   int'(busy),   0);
    reset = 1'b1;
    watch(12, cnt, first, tk, dg, blow, vbad);
    check("rstkey_count",   cnt,       1);
    check("rstkey_latency", first,     7);
    check("rstkey_tenkey",  int'(tk),  10'h002);
    check("rstkey_digit",   int'(dg),  1);
    key_raw = 10'h000;
    watch(12, cnt, first, tk, dg, blow, vbad);
    check("rstkey_rel_count", cnt, 0);

    // Table of single press/release vectors.
    for (int i = 0; i < 11; i++) begin
      key_raw = vecs[i].pat;
      watch(vecs[i].hold, cnt, first, tk, dg, blow, vbad);
      check($sformatf("v%0d_count", i),  cnt,      vecs[i].exp_cnt);
      check($sformatf("v%0d_tenkey", i), int'(tk), int'(vecs[i].exp_tk));
      check($sformatf("v%0d_valid", i),  vbad,     0);
      if (vecs[i].exp_cnt == 1) begin
        check($sformatf("v%0d_latency", i), first,    7);
        check($sformatf("v%0d_sdigit", i),  int'(dg), int'(vecs[i].exp_dg));
      end
      key_raw = 10'h000;
      watch(12, cnt, first, tk, dg, blow, vbad);
      check($sformatf("v%0d_relcount", i), cnt,         0);
      check($sformatf("v%0d_busyfall", i), blow,        7);
      check($sformatf("v%0d_digit", i),    int'(digit), int'(vecs[i].exp_dg));
    end

    // Bounce: key9 toggles every 2 cycles for 10 cycles, then stays high.
    cnt = 0; first = -1; tk = 10'h000;
    for (int t = 1; t <= 30; t++) begin
      key_raw = (t > 10 || (((t - 1) / 2) % 2) == 0) ? 10'h200 : 10'h000;
      @(posedge ck); #1;
      if (tenkey != 10'h000) begin
        cnt++;
        if (first < 0) begin first = t; tk = tenkey; end
      end
    end
    check("bounce_count",   cnt,      1);
    check("bounce_latency", first,    15);
    check("bounce_tenkey",  int'(tk), 10'h200);
    key_raw = 10'h000;
    watch(12, cnt, first, tk, dg, blow, vbad);
    check("bounce_relcount", cnt, 0);

    // Multi-key with partial release: nothing until full release and a fresh key5.
    key_raw = 10'h202;
    watch(12, cnt, first, tk, dg, blow, vbad);
    check("multi_count", cnt, 0);
    key_raw = 10'h200;
    watch(12, cnt, first, tk, dg, blow, vbad);
    check("multi_part_count", cnt,        0);
    check("multi_part_busy",  int'(busy), 1);
    key_raw = 10'h000;
    watch(12, cnt, first, tk, dg, blow, vbad);
    check("multi_rel_count",  cnt,  0);
    check("multi_rel_busy",   blow, 7);
    key_raw = 10'h020;
    watch(12, cnt, first, tk, dg, blow, vbad);
    check("multi_k5_count",  cnt,      1);
    check("multi_k5_tenkey", int'(tk), 10'h020);
    check("multi_k5_digit",  int'(dg), 5);
    key_raw = 10'h000;
    watch(12, cnt, first, tk, dg, blow, vbad);

`ifdef TENKEY_CLOSE_EN
    // Close key: one close strobe, no tenkey strobe, digit held.
    begin
      int ccnt;
      ccnt = 0;
      close_raw = 1'b1;
      cnt = 0;
      for (int t = 1; t <= 12; t++) begin
        @(posedge ck); #1;
        if (close) ccnt++;
        if (tenkey != 10'h000) cnt++;
      end
      close_raw = 1'b0;
      watch(12, first, blow, tk, dg, blow, vbad);
      check("close_count",  ccnt,        1);
      check("close_tenkey", cnt,         0);
      check("close_digit",  int'(digit), 5);
    end
`endif

    // Reset in the middle of a press discards it.
    key_raw = 10'h010;
    repeat (5) @(posedge ck);
    #2 reset = 1'b0;
    #1;
    check("midrst_tenkey", int'(tenkey), 0);
    check("midrst_digit",  int'(digit),  0);
    check("midrst_busy",   int'(busy),   0);
    key_raw = 10'h000;
    repeat (2) @(posedge ck);
    #1 reset = 1'b1;
    watch(15, cnt, first, tk, dg, blow, vbad);
    check("midrst_count",    cnt,        0);
    check("midrst_busy_end", int'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
